// File: rtl/program_loader.sv
// program_loader: boot-time writer for the CPU instruction memory.
// Accepts a framed byte stream (LEN_HI, LEN_LO, N*4 data bytes, 4 checksum
// bytes, all MSB first). Each data word goes to BASE_ADDR + 4*index with a
// single-cycle im_we pulse. The XOR of all data words is compared against the
// trailing checksum. cpu_reset stays high until a load completes cleanly.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   start                 one-cycle pulse that begins a load (ignored while busy)
//   rx_data/valid/ready   byte stream handshake (transfer = valid & ready)
//   im_we/addr/wdata      instruction memory write port
//   cpu_reset             CPU core reset, released only in DONE
//   busy, done, error     load status; done/error sticky until next start/reset
module program_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'd1 << ADDR_WIDTH;

  state_t      state, state_n;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [16:0] idx;      // one bit wider than len so 2**16 words never wraps
  logic [1:0]  bcnt;
  logic [23:0] asm_q;    // first three bytes of the word being assembled
  logic [31:0] acc;

  logic        xfer, idle_like, last_byte, last_word, busy_n;
  logic [31:0] word;
  logic [15:0] len_in;

  assign xfer      = rx_valid & rx_ready;
  assign word      = {asm_q, rx_data};
  assign len_in    = {len_hi, rx_data};
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign last_byte = (bcnt == 2'd3);
  assign last_word = ((idx + 17'd1) == {1'b0, len});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_n = S_LEN_HI;
      S_LEN_HI: if (xfer) state_n = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
        if ({1'b0, len_in} > MAX_N) state_n = S_ERROR;
        else if (len_in == 16'd0)   state_n = S_CHECK;
        else                        state_n = S_WORD;
      end
      S_WORD:  if (xfer && last_byte && last_word) state_n = S_CHECK;
      S_CHECK: if (xfer && last_byte) state_n = (word == acc) ? S_DONE : S_ERROR;
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
             (state_n == S_WORD)   || (state_n == S_CHECK);
  end

  // Status outputs are registered from the next state so they line up with
  // the state register and need no extra decode after the flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready  <= 1'b0;
      im_we     <= 1'b0;
      im_addr   <= BASE_ADDR;
      im_wdata  <= 32'h0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len_hi    <= 8'h0;
      len       <= 16'h0;
      idx       <= 17'h0;
      bcnt      <= 2'd0;
      asm_q     <= 24'h0;
      acc       <= 32'h0;
    end else begin
      im_we     <= 1'b0;
      rx_ready  <= busy_n;
      busy      <= busy_n;
      done      <= (state_n == S_DONE);
      error     <= (state_n == S_ERROR);
      cpu_reset <= (state_n != S_DONE);
      if (idle_like && start) begin
        idx  <= 17'h0;
        acc  <= 32'h0;
        bcnt <= 2'd0;
      end
      if (xfer) begin
        case (state)
          S_LEN_HI: len_hi <= rx_data;
          S_LEN_LO: len    <= len_in;
          S_WORD, S_CHECK: begin
            // bcnt wraps to 0 after each word, so CHECK starts aligned
            asm_q <= word[23:0];
            bcnt  <= bcnt + 2'd1;
            if (state == S_WORD && last_byte) begin
              im_we    <= 1'b1;
              im_addr  <= BASE_ADDR + {13'd0, idx, 2'b00};
              im_wdata <= word;
              acc      <= acc ^ word;
              idx      <= idx + 17'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed bench for program_loader. Inputs change on the
// falling edge; a falling-edge monitor logs every im_we write for the tests.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, im_we, cpu_reset, busy, done, error;
  logic [31:0] im_addr, im_wdata;

  int total = 0;
  int bad = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error)
  );

  always @(negedge clk) begin
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_wdata);
    end
  end

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++; bad++;
      $display("FAIL handshake_timeout byte=%h rx_ready=%b required 1", b, rx_ready);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$], input int max_gap);
    foreach (q[i]) send_byte(q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string name, input logic d, input logic e,
                              input logic cr, input logic b);
    // plain status sampling, comparisons are inline below
    total++;
    if ({done, error, cpu_reset, busy, rx_ready} !== {d, e, cr, b, b}) begin
      bad++;
      $display("FAIL %s done/error/cpu_reset/busy/rx_ready=%b%b%b%b%b required %b%b%b%b%b",
               name, done, error, cpu_reset, busy, rx_ready, d, e, cr, b, b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_reset, rx_ready, im_we, busy, done, error} !== 6'b100000 ||
        im_addr !== 32'h0 || im_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_values cr/rdy/we/busy/done/err=%b%b%b%b%b%b addr=%h wdata=%h required 100000 0 0",
               cpu_reset, rx_ready, im_we, busy, done, error, im_addr, im_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
    // rx_valid while not ready must be ignored
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check_status("idle_ignores_valid", 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_two_writes(input string name);
    total++;
    if (wa.size() != 2 || wa[0] !== 32'h0 || wd[0] !== 32'h20080005 ||
        wa[1] !== 32'h4 || wd[1] !== 32'hAC080000) begin
      bad++;
      $display("FAIL %s writes=%0d w0=%h@%h w1=%h@%h required 2 20080005@0 ac080000@4",
               name, wa.size(), (wa.size() > 0) ? wd[0] : 32'hx, (wa.size() > 0) ? wa[0] : 32'hx,
               (wa.size() > 1) ? wd[1] : 32'hx, (wa.size() > 1) ? wa[1] : 32'hx);
    end
  endtask

  task automatic test_load_ok();
    wa.delete(); wd.delete();
    pulse_start();
    check_status("busy_after_start", 1'b0, 1'b0, 1'b1, 1'b1);
    send_list('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08,
                8'h00, 8'h00, 8'h8C, 8'h00, 8'h00, 8'h05}, 0);
    check_two_writes("ok_writes");
    check_status("ok_status", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_checksum();
    wa.delete(); wd.delete();
    pulse_start();
    send_list('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08,
                8'h00, 8'h00, 8'h8C, 8'h00, 8'h00, 8'h04}, 0);
    check_two_writes("badsum_writes");
    check_status("badsum_status", 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_length_bounds();
    logic [7:0]  q[$];
    logic [31:0] w, sum;
    int          errs;
    // 257 words exceeds the 256-word memory
    wa.delete(); wd.delete();
    pulse_start();
    send_list('{8'h01, 8'h01}, 0);
    check_status("len257_status", 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL len257_writes count=%0d required 0", wa.size());
    end
    // empty load with zero checksum
    pulse_start();
    send_list('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
    check_status("len0_status", 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL len0_writes count=%0d required 0", wa.size());
    end
    // exactly 256 words fills the memory
    q = '{8'h01, 8'h00};
    sum = 32'h0;
    for (int i = 0; i < 256; i++) begin
      w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3};
      sum ^= w;
      q.push_back(w[31:24]); q.push_back(w[23:16]); q.push_back(w[15:8]); q.push_back(w[7:0]);
    end
    q.push_back(sum[31:24]); q.push_back(sum[23:16]); q.push_back(sum[15:8]); q.push_back(sum[7:0]);
    wa.delete(); wd.delete();
    pulse_start();
    send_list(q, 0);
    check_status("len256_status", 1'b1, 1'b0, 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < wa.size(); i++) begin
      w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3};
      if (wa[i] !== 32'(i * 4) || wd[i] !== w) errs++;
    end
    total++;
    if (wa.size() != 256 || errs != 0) begin
      bad++;
      $display("FAIL len256_writes count=%0d wrong=%0d required 256 0", wa.size(), errs);
    end
  endtask

  task automatic test_gaps_and_abort();
    wa.delete(); wd.delete();
    pulse_start();
    send_list('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08,
                8'h00, 8'h00, 8'h8C, 8'h00, 8'h00, 8'h05}, 3);
    check_two_writes("gap_writes");
    check_status("gap_status", 1'b1, 1'b0, 1'b0, 1'b0);
    // abort after six bytes: one word already written must stay the only one
    wa.delete(); wd.delete();
    pulse_start();
    send_list('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05}, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_data = 8'hAC; rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    rx_valid = 1'b0;
    check_status("abort_status", 1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (wa.size() != 1 || wd[0] !== 32'h20080005) begin
      bad++;
      $display("FAIL abort_writes count=%0d required 1 of 20080005", wa.size());
    end
  endtask

  task automatic test_back_to_back_start();
    wa.delete(); wd.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    start = 1'b1;                // coincides with an accepted byte
    send_byte(8'h11, 0);
    start = 1'b0;
    rx_valid = 1'b0;
    pulse_start();               // plain start while busy
    check_status("start_busy_ignored", 1'b0, 1'b0, 1'b1, 1'b1);
    send_list('{8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44}, 0);
    check_status("busy_start_done", 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'h11223344) begin
      bad++;
      $display("FAIL busy_start_writes count=%0d required 1 of 11223344@0", wa.size());
    end
    // restart from DONE re-asserts cpu_reset immediately
    wa.delete(); wd.delete();
    pulse_start();
    check_status("restart_from_done", 1'b0, 1'b0, 1'b1, 1'b1);
    send_list('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 0);
    check_status("restart_done", 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL restart_writes count=%0d required 1 of deadbeef@0", wa.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load_ok();
    test_bad_checksum();
    test_length_bounds();
    test_gaps_and_abort();
    test_back_to_back_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
